// File: rtl/alu_control_pipe.sv
// Registered, valid/ready-handshaked ALU control decoder: {alu_op, opcode} -> alu_cnt/alu_ill.
// Define ALU_CTRL_MULTICYCLE_EN to decode MUL/DIV and stall issue for MC_CYCLES after each.
module alu_control_pipe #(
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned R_BASE    = 2,
  parameter int unsigned R_COUNT   = 8,
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          alu_op,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    alu_cnt,
  output logic                alu_ill,
  output logic                alu_mc,
  output logic                busy
);

  if (MC_CYCLES < 2) begin : g_mc_chk
    $error("MC_CYCLES below 2");
  end
  if ((2 ** CNT_W) < (R_COUNT + 2)) begin : g_cnt_chk
    $error("CNT_W too narrow for R_COUNT");
  end

  localparam int unsigned ExtW = OPCODE_W + 1;
  // One extra bit keeps R_BASE+R_COUNT(+1) comparable without wrapping.
  localparam logic [ExtW-1:0] RLo = ExtW'(R_BASE);
  localparam logic [ExtW-1:0] RHi = ExtW'(R_BASE + R_COUNT);

`ifdef ALU_CTRL_MULTICYCLE_EN
  localparam int unsigned McW = $clog2(MC_CYCLES);
  typedef enum logic [1:0] {StIdle, StFull, StStall} state_e;
`else
  typedef enum logic [0:0] {StIdle, StFull} state_e;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ill_q, ill_d;
  logic [ExtW-1:0]     opc_ext;
  logic [OPCODE_W-1:0] rel;
  logic [CNT_W-1:0]    dec_cnt;
  logic                dec_ill;
  logic                held_mc;
`ifdef ALU_CTRL_MULTICYCLE_EN
  logic                mc_q, mc_d;
  logic                dec_mc;
  logic [McW-1:0]      mcc_q, mcc_d;
`endif

  assign opc_ext = {1'b0, opcode};
  assign rel     = opcode - OPCODE_W'(R_BASE);

  always_comb begin
    dec_cnt = '0;
    dec_ill = 1'b0;
`ifdef ALU_CTRL_MULTICYCLE_EN
    dec_mc  = 1'b0;
`endif
    case (alu_op)
      2'b10: dec_cnt = '0;
      2'b01: dec_cnt = CNT_W'(1);
      2'b00: begin
        if (opc_ext >= RLo && opc_ext < RHi) dec_cnt = rel[CNT_W-1:0];
`ifdef ALU_CTRL_MULTICYCLE_EN
        else if (opc_ext == RHi) begin
          dec_cnt = CNT_W'(R_COUNT);
          dec_mc  = 1'b1;
        end else if (opc_ext == RHi + ExtW'(1)) begin
          dec_cnt = CNT_W'(R_COUNT + 1);
          dec_mc  = 1'b1;
        end
`endif
        else dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

`ifdef ALU_CTRL_MULTICYCLE_EN
  assign held_mc = mc_q;
`else
  assign held_mc = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ill_d    = ill_q;
    in_ready = 1'b0;
`ifdef ALU_CTRL_MULTICYCLE_EN
    mc_d     = mc_q;
    mcc_d    = mcc_q;
`endif
    case (state_q)
      StIdle: in_ready = rst_n;
      StFull: begin
        in_ready = rst_n & out_ready & ~held_mc;
        if (out_ready) begin
          state_d = StIdle;
`ifdef ALU_CTRL_MULTICYCLE_EN
          if (mc_q) begin
            state_d = StStall;
            mcc_d   = McW'(MC_CYCLES - 1);
          end
`endif
        end
      end
`ifdef ALU_CTRL_MULTICYCLE_EN
      StStall: begin
        mcc_d = mcc_q - McW'(1);
        if (mcc_q == McW'(1)) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
    // A same-cycle accept overrides the drain to IDLE.
    if (in_valid && in_ready) begin
      state_d = StFull;
      cnt_d   = dec_cnt;
      ill_d   = dec_ill;
`ifdef ALU_CTRL_MULTICYCLE_EN
      mc_d    = dec_mc;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
`ifdef ALU_CTRL_MULTICYCLE_EN
      mc_q    <= 1'b0;
      mcc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
`ifdef ALU_CTRL_MULTICYCLE_EN
      mc_q    <= mc_d;
      mcc_q   <= mcc_d;
`endif
    end
  end

  assign out_valid = (state_q == StFull);
  assign alu_cnt   = cnt_q;
  assign alu_ill   = ill_q;
`ifdef ALU_CTRL_MULTICYCLE_EN
  assign alu_mc    = mc_q;
  assign busy      = (state_q == StStall);
`else
  assign alu_mc    = 1'b0;
  assign busy      = 1'b0;
`endif

endmodule
